mux_n_1_arb_v: RTL

- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake and selectable arbitration mode.
- Successor to the combinational 4:1 code mux. Adds an output register stage, backpressure, round-robin and burst round-robin selection, and reports which channel is being presented.
- Sits between several code producers and a single downstream consumer in the datapath.

---
 rtl/mux_n_1_arb_v_pkg.sv | 20 ++
 rtl/mux_n_1_arb_v_rr.sv | 24 ++
 rtl/mux_n_1_arb_v.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mux_n_1_arb_v_pkg.sv
// Shared mode encodings and flattened-bus slicing helper for the N:1 arbitrating mux.
package mux_arb_pkg_v;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_RR     = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;

  // Upper bounds for the slicing helper; callers zero-extend into this width and truncate the result.
  localparam int MAX_CH = 16;
  localparam int MAX_W  = 64;

  function automatic logic [MAX_W-1:0] ch_slice(input logic [MAX_CH*MAX_W-1:0] bus,
                                                input int w,
                                                input int idx);
    logic [MAX_CH*MAX_W-1:0] sh;
    sh = bus >> (w * idx);
    return sh[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/mux_n_1_arb_v_rr.sv
// Combinational round-robin search: first requester strictly after ptr, wrapping modulo N_CH.
module rr_arbiter_v #(
  parameter int N_CH = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // Walk from farthest to nearest so the nearest requester is the last (winning) assignment.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N_CH]) begin
        gnt_idx = SEL_W'((int'(ptr) + k) % N_CH);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_arb_v.sv
// N-channel registered mux with valid/ready per channel and direct / round-robin / burst arbitration.
// One-cycle latency; i_ready feeds o_ready combinationally so a beat can drain and reload each cycle.
module mux_n_1_arb_v
  import mux_arb_pkg_v::*;
#(
  parameter int N_CH    = 4,
  parameter int W       = 8,
  parameter int P_BURST = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic [SEL_W-1:0]  i_sel_code,
  input  logic [N_CH*W-1:0] i_code,
  input  logic [N_CH-1:0]   i_valid,
  output logic [N_CH-1:0]   o_ready,
  output logic [W-1:0]      o_code,
  output logic              o_valid,
  output logic [SEL_W-1:0]  o_sel_code,
  input  logic              i_ready
);

  localparam int CNT_W = 4;

  logic [W-1:0]       o_code_q, o_code_d;
  logic               o_valid_q, o_valid_d;
  logic [SEL_W-1:0]   o_sel_q, o_sel_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic [MAX_CH*MAX_W-1:0] code_bus;
  logic [N_CH-1:0]    v_sel_sh, v_lock_sh;
  logic [SEL_W-1:0]   rr_idx, g;
  logic               rr_vld, gv, burst_open, lock_hold, load_ok, xfer;

  rr_arbiter_v #(.N_CH(N_CH)) u_rr (
    .req     (i_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Shifts keep an out-of-range select from indexing past the valid vector.
  assign v_sel_sh   = i_valid >> i_sel_code;
  assign v_lock_sh  = i_valid >> lock_ch_q;
  assign burst_open = (burst_cnt_q != '0) && (burst_cnt_q < CNT_W'(P_BURST));
  assign lock_hold  = v_lock_sh[0] && burst_open;
  assign load_ok    = i_en && (!o_valid_q || i_ready);

  always_comb begin
    code_bus = '0;
    code_bus[N_CH*W-1:0] = i_code;
  end

  always_comb begin
    g  = i_sel_code;
    gv = (int'(i_sel_code) < N_CH) && v_sel_sh[0];
    case (i_mode)
      MODE_RR: begin
        g  = rr_idx;
        gv = rr_vld;
      end
      MODE_BURST: begin
        g  = lock_hold ? lock_ch_q : rr_idx;
        gv = lock_hold | rr_vld;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ready = '0;
    if (load_ok && gv && !i_rst) o_ready[g] = 1'b1;
  end

  assign xfer = |(o_ready & i_valid);

  always_comb begin
    o_code_d    = o_code_q;
    o_valid_d   = o_valid_q;
    o_sel_d     = o_sel_q;
    rr_ptr_d    = rr_ptr_q;
    lock_ch_d   = lock_ch_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer) begin
      o_code_d  = W'(ch_slice(code_bus, W, int'(g)));
      o_sel_d   = g;
      o_valid_d = 1'b1;
      if (i_mode == MODE_RR) begin
        rr_ptr_d    = g;
        burst_cnt_d = '0;
      end else if (i_mode == MODE_BURST) begin
        rr_ptr_d    = g;
        lock_ch_d   = g;
        burst_cnt_d = (g == lock_ch_q && burst_open) ? burst_cnt_q + 1'b1 : CNT_W'(1);
      end else begin
        burst_cnt_d = '0;
      end
    end else if (o_valid_q && i_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_code_q    <= '0;
      o_valid_q   <= 1'b0;
      o_sel_q     <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
      lock_ch_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      o_code_q    <= o_code_d;
      o_valid_q   <= o_valid_d;
      o_sel_q     <= o_sel_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_ch_q   <= lock_ch_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign o_code     = o_code_q;
  assign o_valid    = o_valid_q;
  assign o_sel_code = o_sel_q;

endmodule
